// File: rtl/register_n_if.sv
// register_n_if: load/data bus of register_n; REGISTER_N_PARITY_EN adds the parity output
interface register_n_if #(parameter int N = 4);
  logic [N-1:0] d;
  logic         load;
  logic [N-1:0] wmask;
  logic [N-1:0] q;
  logic         updated;
`ifdef REGISTER_N_PARITY_EN
  logic         parity;
  modport master (output d, load, wmask, input q, updated, parity);
  modport slave  (input d, load, wmask, output q, updated, parity);
`else
  modport master (output d, load, wmask, input q, updated);
  modport slave  (input d, load, wmask, output q, updated);
`endif
endinterface

// File: rtl/register_n.sv
// register_n: N-bit register with sync clear, masked load and write strobe; REGISTER_N_PARITY_EN adds registered parity
module register_n #(
  parameter int           N         = 4,
  parameter logic [N-1:0] CLEAR_VAL = {N{1'b0}}
) (
  input logic         clk,
  input logic         clear,
  register_n_if.slave bus
);
  logic [N-1:0] r_q;
  logic         r_updated;
  logic [N-1:0] w_q_next;
  assign w_q_next = clear ? CLEAR_VAL
                  : bus.load ? ((bus.wmask & bus.d) | (~bus.wmask & r_q)) : r_q;
  always_ff @(posedge clk) begin
    r_q       <= w_q_next;
    r_updated <= !clear && bus.load;
  end
  assign bus.q       = r_q;
  assign bus.updated = r_updated;
`ifdef REGISTER_N_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk) r_parity <= ^w_q_next;
  assign bus.parity = r_parity;
`endif
endmodule

// File: tb/tb_register_n.sv
// tb_register_n: directed checks of clear priority, hold, masked load, strobe and optional parity
module tb_register_n;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int total = 0;
  int bad = 0;
  register_n_if #(.N(4)) bus();
  register_n #(.N(4)) dut (.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    assert (!$isunknown({clear, bus.load})) else $error("X/Z on clear or load");
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] q_exp, input logic upd_exp);
    total++;
    if (bus.q !== q_exp) begin
      bad++;
      $display("FAIL %s q: got %b want %b", name, bus.q, q_exp);
    end
    total++;
    if (bus.updated !== upd_exp) begin
      bad++;
      $display("FAIL %s updated: got %b want %b", name, bus.updated, upd_exp);
    end
  endtask
  task automatic drive(input logic c, input logic l, input logic [3:0] dv, input logic [3:0] m);
    clear = c;
    bus.load = l;
    bus.d = dv;
    bus.wmask = m;
  endtask
  task automatic test_reset();
    drive(1, 0, 4'b0000, 4'b1111);
    step();
    chk("reset", 4'b0000, 0);
  endtask
  task automatic test_clear_priority();
    drive(1, 1, 4'b0001, 4'b1111);
    step();
    chk("clear_priority", 4'b0000, 0);
  endtask
  task automatic test_hold();
    drive(0, 0, 4'b0001, 4'b1111);
    step();
    chk("hold1", 4'b0000, 0);
    step();
    chk("hold2", 4'b0000, 0);
  endtask
  task automatic test_load();
    drive(0, 1, 4'b0001, 4'b1111);
    step();
    chk("load", 4'b0001, 1);
    drive(0, 0, 4'b1111, 4'b1111);
    step();
    chk("load_then_hold", 4'b0001, 0);
  endtask
  task automatic test_masked_load();
    drive(0, 1, 4'b1010, 4'b1100);
    step();
    chk("masked_load", 4'b1001, 1);
    drive(0, 1, 4'b0110, 4'b0000);
    step();
    chk("zero_mask_strobe", 4'b1001, 1);
    drive(1, 0, 4'b0000, 4'b1111);
    #1;
    chk("clear_not_async", 4'b1001, 1);
    step();
    chk("clear_mid", 4'b0000, 0);
    step();
    chk("clear_held", 4'b0000, 0);
  endtask
  task automatic test_back_to_back();
    drive(0, 1, 4'b0011, 4'b1111);
    step();
    chk("b2b_0", 4'b0011, 1);
    drive(0, 1, 4'b0101, 4'b1111);
    step();
    chk("b2b_1", 4'b0101, 1);
    drive(0, 1, 4'b1010, 4'b1111);
    step();
    chk("b2b_2", 4'b1010, 1);
    drive(0, 1, 4'b0101, 4'b0011);
    step();
    chk("b2b_masked", 4'b1001, 1);
    drive(0, 0, 4'b0000, 4'b1111);
    step();
    chk("b2b_end", 4'b1001, 0);
  endtask
`ifdef REGISTER_N_PARITY_EN
  task automatic chk_par(input string name, input logic p_exp);
    total++;
    if (bus.parity !== p_exp) begin
      bad++;
      $display("FAIL %s parity: got %b want %b", name, bus.parity, p_exp);
    end
  endtask
  task automatic test_parity();
    drive(0, 1, 4'b0111, 4'b1111);
    step();
    chk_par("par_0111", 1);
    drive(0, 0, 4'b0000, 4'b1111);
    step();
    chk_par("par_hold", 1);
    drive(0, 1, 4'b0110, 4'b1111);
    step();
    chk_par("par_0110", 0);
    drive(0, 1, 4'b0001, 4'b0001);
    step();
    chk_par("par_masked", 1);
    drive(1, 0, 4'b0000, 4'b1111);
    step();
    chk_par("par_clear", 0);
  endtask
`endif
  initial begin
    drive(1, 0, 4'b0000, 4'b1111);
    test_reset();
    test_clear_priority();
    test_hold();
    test_load();
    test_masked_load();
    test_back_to_back();
`ifdef REGISTER_N_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
